// File: rtl/census_wta_disparity.sv
// Census-transform stereo matcher: Hamming cost over MAX_DISP candidates with
// winner-takes-all selection, three pipeline stages after pixel acceptance.
module census_wta_disparity #(
    parameter int WIDTH    = 12,
    parameter int HEIGHT   = 12,
    parameter int MAX_DISP = 16,
    localparam int DW = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1,
    localparam int XW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1,
    localparam int YW = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [24:0]   left_census,
    input  logic [24:0]   right_census,
    input  logic          in_valid,
    output logic [DW-1:0] disp_out,
    output logic [4:0]    cost_out,
    output logic          disp_valid,
    output logic          sof_out,
    output logic          eol_out
);

    // Streams are pre-aligned, no backpressure: a pixel is accepted on every
    // rising edge where in_valid is high, and its result appears on
    // disp_valid exactly three cycles later.

    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [24:0]   r_hist [MAX_DISP];

    logic [24:0]         cand [MAX_DISP];
    logic [MAX_DISP-1:0] elig;

    always_comb begin
        cand[0] = right_census;
        for (int d = 1; d < MAX_DISP; d++) cand[d] = r_hist[d-1];
        elig = '0;
        for (int d = 0; d < MAX_DISP; d++) elig[d] = (d <= int'(x_pos));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
            for (int k = 0; k < MAX_DISP; k++) r_hist[k] <= '0;
        end else if (in_valid) begin
            r_hist[0] <= right_census;
            for (int k = 1; k < MAX_DISP; k++) r_hist[k] <= r_hist[k-1];
            if (x_pos == XW'(WIDTH - 1)) begin
                x_pos <= '0;
                y_pos <= (y_pos == YW'(HEIGHT - 1)) ? '0 : y_pos + 1'b1;
            end else begin
                x_pos <= x_pos + 1'b1;
            end
        end
    end

    logic                s1_valid, s1_sof, s1_eol;
    logic [24:0]         s1_left;
    logic [24:0]         s1_right [MAX_DISP];
    logic [MAX_DISP-1:0] s1_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_left  <= '0;
            s1_mask  <= '0;
            for (int d = 0; d < MAX_DISP; d++) s1_right[d] <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_left <= left_census;
                s1_mask <= elig;
                s1_sof  <= (x_pos == '0) && (y_pos == '0);
                s1_eol  <= (x_pos == XW'(WIDTH - 1));
                for (int d = 0; d < MAX_DISP; d++) s1_right[d] <= cand[d];
            end
        end
    end

    logic                s2_valid, s2_sof, s2_eol;
    logic [4:0]          s2_cost [MAX_DISP];
    logic [MAX_DISP-1:0] s2_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_mask  <= '0;
            for (int d = 0; d < MAX_DISP; d++) s2_cost[d] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sof  <= s1_sof;
                s2_eol  <= s1_eol;
                s2_mask <= s1_mask;
                for (int d = 0; d < MAX_DISP; d++)
                    s2_cost[d] <= 5'($countones(s1_left ^ s1_right[d]));
            end
        end
    end

    // Start above the largest possible cost so d = 0 (always eligible) seeds
    // the search; strict less-than keeps the smallest d on ties.
    logic [4:0]    best_cost;
    logic [DW-1:0] best_idx;

    always_comb begin
        best_cost = 5'd31;
        best_idx  = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (s2_mask[d] && (s2_cost[d] < best_cost)) begin
                best_cost = s2_cost[d];
                best_idx  = DW'(d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_out   <= '0;
            cost_out   <= '0;
            sof_out    <= 1'b0;
            eol_out    <= 1'b0;
        end else begin
            disp_valid <= s2_valid;
            if (s2_valid) begin
                disp_out <= best_idx;
                cost_out <= best_cost;
                sof_out  <= s2_sof;
                eol_out  <= s2_eol;
            end
        end
    end

endmodule

// File: tb/tb_census_wta_disparity.sv
// Randomized and directed stimulus for census_wta_disparity, checked against a
// per-line array model of the matching rules with a timestamped expected queue.
module tb_census_wta_disparity;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int MD = 16;

    logic        clk;
    logic        rst_n;
    logic [24:0] left_census;
    logic [24:0] right_census;
    logic        in_valid;
    logic [3:0]  disp_out;
    logic [4:0]  cost_out;
    logic        disp_valid;
    logic        sof_out;
    logic        eol_out;

    census_wta_disparity #(.WIDTH(W), .HEIGHT(H), .MAX_DISP(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .left_census(left_census), .right_census(right_census),
        .in_valid(in_valid),
        .disp_out(disp_out), .cost_out(cost_out), .disp_valid(disp_valid),
        .sof_out(sof_out), .eol_out(eol_out)
    );

    // clock / cycle stamp
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: item = {sof, eol, cost[4:0], disp[3:0]}
    logic [10:0] exp_q[$];
    int          stamp_q[$];
    logic [10:0] last_exp = '0;
    logic [24:0] row_r [W];
    int          mx = 0;
    int          my = 0;

    task automatic model_accept(input logic [24:0] l, input logic [24:0] r);
        int best_c, best_d, c;
        logic [10:0] item;
        row_r[mx] = r;
        best_c = 99;
        best_d = 0;
        for (int d = 0; d < MD && d <= mx; d++) begin
            c = $countones(l ^ row_r[mx-d]);
            if (c < best_c) begin
                best_c = c;
                best_d = d;
            end
        end
        item = {(mx == 0 && my == 0), (mx == W - 1), 5'(best_c), 4'(best_d)};
        exp_q.push_back(item);
        stamp_q.push_back(cyc + 3);
        if (mx == W - 1) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    // driver tasks
    task automatic send(input logic [24:0] l, input logic [24:0] r);
        @(negedge clk);
        in_valid     = 1'b1;
        left_census  = l;
        right_census = r;
        model_accept(l, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid     = 1'b0;
            left_census  = 25'($urandom);
            right_census = 25'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        stamp_q.delete();
        mx = 0;
        my = 0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // scoreboard / monitor
    int n_valid = 0;
    int n_sof   = 0;
    int n_eol   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("valid_in_reset", {31'd0, disp_valid}, 32'd0);
            check("outs_in_reset", {21'd0, sof_out, eol_out, cost_out, disp_out}, 32'd0);
        end else if (disp_valid) begin
            n_valid++;
            if (sof_out) n_sof++;
            if (eol_out) n_eol++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("result", {21'd0, sof_out, eol_out, cost_out, disp_out}, {21'd0, last_exp});
                check("latency", cyc, stamp_q.pop_front());
            end
        end else begin
            check("hold", {21'd0, sof_out, eol_out, cost_out, disp_out}, {21'd0, last_exp});
        end
    end

    logic [24:0] fl [H][W];
    logic [24:0] fr [H][W];
    logic [24:0] v  [W+5];

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        left_census  = '0;
        right_census = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", {31'd0, disp_valid}, 32'd0);
        check("rst_disp", {28'd0, disp_out}, 32'd0);
        check("rst_cost", {27'd0, cost_out}, 32'd0);
        check("rst_flags", {30'd0, sof_out, eol_out}, 32'd0);

        // shifted ramp: right is left shifted by 5 columns, unique per column
        for (int y = 0; y < H; y++) begin
            for (int c = 0; c < W + 5; c++) v[c] = {5'(c), 4'(y), 16'($urandom)};
            for (int x = 0; x < W; x++) begin
                fl[y][x] = v[x];
                fr[y][x] = v[x+5];
            end
        end
        n_valid = 0; n_sof = 0; n_eol = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) send(fl[y][x], fr[y][x]);
        idle(6);
        check("count_valid", n_valid, 32'd144);
        check("count_sof", n_sof, 32'd1);
        check("count_eol", n_eol, 32'd12);

        // same frame with in_valid alternating
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send(fl[y][x], fr[y][x]);
                idle(1);
            end
        idle(4);

        // tie line: all vectors identical
        for (int x = 0; x < W; x++) send(25'h0000001, 25'h0000001);

        // true match at d = 7, clipped by eligibility at small x
        for (int x = 0; x < W + 7; x++) v[x] = 25'($urandom);
        for (int x = 0; x < W; x++) send(v[x], v[x+7]);
        idle(2);

        // random data with random gaps
        for (int i = 0; i < 3 * W; i++) begin
            send(25'($urandom), 25'($urandom));
            idle($urandom_range(0, 2));
        end

        // reset mid-frame at pixel (4,6)
        do_reset();
        for (int i = 0; i <= 6 * W + 4; i++) send(25'($urandom), 25'($urandom));
        do_reset();
        idle(2);
        send(25'($urandom), 25'($urandom));
        send(25'($urandom), 25'($urandom));
        idle(6);

        check("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
